coder_emulator: RTL and testbench
=================================

# coder_emulator

Quadrature encoder emulator. It generates the A/B phase pair that the coder input path decodes, at a programmed step rate, direction and step count. The block sits in the FPGA core under ARM register control and feeds the coder decoder through a self-test mux ahead of the CODER_A/CODER_B pins. It is the transmit end of the encoder interface, used for field self-test and bench verification of position tracking.

## Interface
- DIV_W, 16, width of the step-interval divider
- CNT_W, 32, width of the step target and the position counter

- clk_sys  in  1  system clock (80 MHz); sole clock
- RESET_IN  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse; begins a run when idle
- stop  in  1  one-cycle pulse; aborts a run
- dir  in  1  1 = forward (A leads B), 0 = reverse
- interval  in  DIV_W  clk_sys cycles per quadrature step
- step_target  in  CNT_W  steps per run; 0 = continuous until stop
- coder_a  out  1  phase A
- coder_b  out  1  phase B
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse when step_target is reached
- position  out  CNT_W  signed emitted-step count

## Operation
- States: IDLE, RUN.
- IDLE: on start, load div = max(interval,2)-1, clear step counter, go to RUN. stop in IDLE is ignored.
- RUN: div decrements every cycle. When div==0: advance the phase one step, reload div, increment the step counter, update position.
- Forward sequence {A,B}: 00→10→11→01→00. Reverse is the exact inverse. Phase state persists across runs; it is never reset by start.
- dir and interval are sampled at each step, so mid-run changes apply from the next step. A direction change reverses from the current phase, with no skipped state.
- position: +1 forward, −1 reverse, wraps modulo 2^CNT_W. It is cleared only by reset.
- The step counter is unsigned. If step_target≠0 and the counter reaches step_target on a step, assert done for 1 cycle (same cycle the counter updates) and return to IDLE.
- stop in RUN: go to IDLE next cycle. A/B hold their current levels and done is not asserted. If stop and the final step coincide, the step is emitted and done is asserted; stop has no further effect.
- start while in RUN is ignored.
- interval 0 or 1 clamps to 2, giving a maximum step rate of clk_sys/2.

## Timing
- Reset values: coder_a=0, coder_b=0, busy=0, done=0, position=0, state IDLE, div=0, step counter=0.
- busy rises the cycle after start is sampled.
- First phase edge is registered exactly N cycles after the start cycle, where N = max(interval,2). Subsequent edges follow every N cycles.
- A/B come directly from flops, with no combinational path from any input.
- done and the falling edge of busy occur in the same cycle as the final phase edge.
- Reset asserted mid-run: all of the above reset values apply on the next edge. Outputs go to 00 even if that is a non-adjacent Gray jump; downstream decode must tolerate this after reset.

## Structure
- A shared package holds:
  - state enum {IDLE, RUN}
  - forward Gray step table and its reverse
  - the minimum-interval constant (2)
- One sub-module, `quad_phase_step`, is natural: a 2-bit Gray phase register with step/dir inputs and a ±1 output for the position counter. The top holds the FSM, the divider and the counters.

## Test plan
- interval=10, dir=1, step_target=4, start → edges at +10/+20/+30/+40 cycles; {A,B}=10,11,01,00; position=4; one done pulse at +40; busy low after.
- dir=0, step_target=3 from phase 00 → 01,11,10; position=−3.
- step_target=0, interval=2 → continuous toggling every 2 cycles. stop at an arbitrary cycle → busy drops next cycle, A/B frozen, no done.
- interval=0 → behaves identically to interval=2. Toggle dir mid-run → the next step reverses with no skipped phase, and position increments then decrements.
- Preload position near 2^32−1 via forward steps from −2 (reverse 2 steps first), then forward 3 steps → wraps through 0 to 1.
- Reset asserted mid-run with A/B=11 → next cycle A=B=0, position=0, busy=0. start while RUN and stop while IDLE are both ignored.

Source files
------------

// File: rtl/coder_emulator_pkg.sv
// Shared definitions for the quadrature encoder emulator: FSM states,
// the Gray step tables for both directions and the minimum step interval.
package coder_emulator_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Shortest allowed step interval; caps the step rate at clk_sys/2.
  localparam int unsigned MIN_INTERVAL = 2;

  // Next {A,B} indexed by current {A,B}, packed as {idx3, idx2, idx1, idx0}.
  // Forward: 00->10, 01->00, 10->11, 11->01 (A leads B).
  localparam logic [7:0] FWD_STEP = {2'b01, 2'b11, 2'b00, 2'b10};
  // Reverse: 00->01, 01->11, 10->00, 11->10 (exact inverse of forward).
  localparam logic [7:0] REV_STEP = {2'b10, 2'b00, 2'b11, 2'b01};

  function automatic logic [1:0] next_phase(input logic [1:0] phase, input logic fwd);
    logic [2:0] base;
    base = {phase, 1'b0};
    next_phase = fwd ? FWD_STEP[base +: 2] : REV_STEP[base +: 2];
  endfunction

endpackage

// File: rtl/quad_phase_step.sv
// Two-bit Gray phase register that advances one quadrature step per
// request, plus the signed unit increment matching the step direction.
module quad_phase_step
  import coder_emulator_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         step,
  input  logic         dir,
  output logic [1:0]   phase,
  output logic [W-1:0] delta
);

  // Advance the phase by one Gray step in the requested direction.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= 2'b00;
    end else if (step) begin
      phase <= next_phase(phase, dir);
    end
  end

  assign delta = dir ? W'(1) : {W{1'b1}};

endmodule

// File: rtl/coder_emulator.sv
// Quadrature encoder emulator: emits A/B phase steps at a programmed
// interval, direction and count, tracking a signed position.
module coder_emulator
  import coder_emulator_pkg::*;
#(
  parameter int DIV_W = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk_sys,
  input  logic             RESET_IN,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic [DIV_W-1:0] interval,
  input  logic [CNT_W-1:0] step_target,
  output logic             coder_a,
  output logic             coder_b,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] position
);

  state_t           state;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_load;
  logic [CNT_W-1:0] step_count;
  logic [CNT_W-1:0] count_next;
  logic [CNT_W-1:0] delta;
  logic [1:0]       phase;
  logic             step_due;
  logic             target_hit;

  // Reload value for the divider, with interval 0/1 clamped to the minimum.
  always_comb begin
    div_load = interval - 1'b1;
    if (interval < DIV_W'(MIN_INTERVAL)) begin
      div_load = DIV_W'(MIN_INTERVAL - 1);
    end
  end

  assign step_due   = (state == RUN) && (div == '0);
  assign count_next = step_count + 1'b1;
  assign target_hit = (step_target != '0) && (count_next == step_target);

  quad_phase_step #(
    .W(CNT_W)
  ) u_phase (
    .clk   (clk_sys),
    .reset (RESET_IN),
    .step  (step_due),
    .dir   (dir),
    .phase (phase),
    .delta (delta)
  );

  // Run FSM, step divider, step counter, position and the done pulse.
  // A step that falls due is always emitted; stop only prevents further ones.
  always_ff @(posedge clk_sys) begin
    if (RESET_IN) begin
      state      <= IDLE;
      div        <= '0;
      step_count <= '0;
      position   <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            div        <= div_load;
            step_count <= '0;
            state      <= RUN;
          end
        end
        RUN: begin
          if (div == '0) begin
            div        <= div_load;
            step_count <= count_next;
            position   <= position + delta;
            if (target_hit) begin
              done  <= 1'b1;
              state <= IDLE;
            end else if (stop) begin
              state <= IDLE;
            end
          end else begin
            div <= div - 1'b1;
            if (stop) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign coder_a = phase[1];
  assign coder_b = phase[0];
  assign busy    = (state == RUN);

endmodule

// File: tb/tb_coder_emulator.sv
// Self-checking bench for coder_emulator: a timestamp-based behavioural
// model, a per-cycle compare process, directed pins and random stimulus.
module tb_coder_emulator;

  localparam int DIV_W = 16;
  localparam int CNT_W = 32;

  logic             clk_sys = 1'b0;
  logic             RESET_IN = 1'b1;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             dir = 1'b1;
  logic [DIV_W-1:0] interval = '0;
  logic [CNT_W-1:0] step_target = '0;
  logic             coder_a;
  logic             coder_b;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] position;

  always #5 clk_sys = ~clk_sys;

  coder_emulator #(
    .DIV_W(DIV_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk_sys     (clk_sys),
    .RESET_IN    (RESET_IN),
    .start       (start),
    .stop        (stop),
    .dir         (dir),
    .interval    (interval),
    .step_target (step_target),
    .coder_a     (coder_a),
    .coder_b     (coder_b),
    .busy        (busy),
    .done        (done),
    .position    (position)
  );

  int unsigned compared = 0;
  int unsigned mismatched = 0;

  // Phase positions along the forward cycle; index +1 = forward step.
  logic [1:0] gray_seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  bit          m_valid = 1'b0;
  bit          m_running = 1'b0;
  bit          m_done = 1'b0;
  longint      m_cycle = 0;
  longint      m_next = 0;
  logic [31:0] m_cnt = '0;
  logic [31:0] m_pos = '0;
  int          m_idx = 0;

  int          pin_id = 0;
  int          seen_pin = 0;
  string       pin_name = "";
  logic [1:0]  pin_ab = '0;
  logic [31:0] pin_pos = '0;
  logic        pin_busy = 1'b0;
  logic        pin_done = 1'b0;

  function automatic longint stepLen(input logic [DIV_W-1:0] iv);
    return (iv < 2) ? 64'd2 : longint'(iv);
  endfunction

  // Behavioural model: steps happen at absolute cycle stamps start+N, +N...
  initial begin
    forever begin
      @(posedge clk_sys);
      m_cycle++;
      m_done = 1'b0;
      if (RESET_IN) begin
        m_valid   = 1'b1;
        m_running = 1'b0;
        m_cnt     = '0;
        m_pos     = '0;
        m_idx     = 0;
      end else if (m_valid) begin
        if (!m_running) begin
          if (start) begin
            m_running = 1'b1;
            m_cnt     = '0;
            m_next    = m_cycle + stepLen(interval);
          end
        end else if (m_cycle == m_next) begin
          m_idx  = dir ? (m_idx + 1) % 4 : (m_idx + 3) % 4;
          m_pos  = dir ? m_pos + 32'd1 : m_pos - 32'd1;
          m_cnt  = m_cnt + 32'd1;
          m_next = m_cycle + stepLen(interval);
          if (step_target != 0 && m_cnt == step_target) begin
            m_done    = 1'b1;
            m_running = 1'b0;
          end else if (stop) begin
            m_running = 1'b0;
          end
        end else if (stop) begin
          m_running = 1'b0;
        end
      end
    end
  end

  function automatic void checkOutput(input string name, input logic [31:0] act,
                                      input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, m_cycle, act, exp);
    end
  endfunction

  // Compare process: DUT against model every cycle, plus pinned literals.
  initial begin
    forever begin
      @(negedge clk_sys);
      if (m_valid) begin
        checkOutput("ab", 32'({coder_a, coder_b}), 32'(gray_seq[m_idx]));
        checkOutput("busy", 32'(busy), 32'(m_running));
        checkOutput("done", 32'(done), 32'(m_done));
        checkOutput("position", position, m_pos);
        if (pin_id != seen_pin) begin
          seen_pin = pin_id;
          checkOutput({pin_name, "_model_ab"}, 32'(gray_seq[m_idx]), 32'(pin_ab));
          checkOutput({pin_name, "_model_pos"}, m_pos, pin_pos);
          checkOutput({pin_name, "_ab"}, 32'({coder_a, coder_b}), 32'(pin_ab));
          checkOutput({pin_name, "_pos"}, position, pin_pos);
          checkOutput({pin_name, "_busy"}, 32'(busy), 32'(pin_busy));
          checkOutput({pin_name, "_done"}, 32'(done), 32'(pin_done));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic pinExpect(input string name, input logic [1:0] ab, input logic [31:0] pos,
                           input logic b, input logic d);
    pin_name = name;
    pin_ab   = ab;
    pin_pos  = pos;
    pin_busy = b;
    pin_done = d;
    pin_id++;
  endtask

  task automatic applyStimulus(input logic d, input logic [DIV_W-1:0] iv,
                               input logic [CNT_W-1:0] tgt);
    dir         = d;
    interval    = iv;
    step_target = tgt;
    start       = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic doReset();
    RESET_IN = 1'b1;
    tick();
    RESET_IN = 1'b0;
  endtask

  logic [1:0]  fwd_ab [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
  logic [1:0]  rev_ab [3] = '{2'b01, 2'b11, 2'b10};
  logic [31:0] rev_pos [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFD};

  initial begin
    tick();
    tick();
    RESET_IN = 1'b0;
    pinExpect("reset", 2'b00, 32'd0, 1'b0, 1'b0);
    tick();

    $display("[TB] forward run, interval 10, 4 steps");
    applyStimulus(1'b1, 16'd10, 32'd4);
    for (int k = 0; k < 4; k++) begin
      repeat (9) tick();
      pinExpect("fwd_pre", (k == 0) ? 2'b00 : fwd_ab[k-1], 32'(k), 1'b1, 1'b0);
      tick();
      pinExpect("fwd_step", fwd_ab[k], 32'(k + 1), (k < 3), (k == 3));
    end
    tick();
    pinExpect("fwd_idle", 2'b00, 32'd4, 1'b0, 1'b0);

    $display("[TB] reverse run, 3 steps from reset");
    doReset();
    applyStimulus(1'b0, 16'd5, 32'd3);
    for (int k = 0; k < 3; k++) begin
      repeat (5) tick();
      pinExpect("rev_step", rev_ab[k], rev_pos[k], (k < 2), (k == 2));
    end

    $display("[TB] continuous run at interval 2, then stop");
    applyStimulus(1'b1, 16'd2, 32'd0);
    repeat (2) tick();
    pinExpect("cont1", 2'b11, 32'hFFFF_FFFE, 1'b1, 1'b0);
    repeat (2) tick();
    pinExpect("cont2", 2'b01, 32'hFFFF_FFFF, 1'b1, 1'b0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    pinExpect("stopped", 2'b01, 32'hFFFF_FFFF, 1'b0, 1'b0);
    repeat (4) tick();
    pinExpect("frozen", 2'b01, 32'hFFFF_FFFF, 1'b0, 1'b0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    pinExpect("idle_stop", 2'b01, 32'hFFFF_FFFF, 1'b0, 1'b0);

    $display("[TB] interval 0 with direction change and start during run");
    applyStimulus(1'b1, 16'd0, 32'd0);
    repeat (2) tick();
    pinExpect("iv0_fwd", 2'b00, 32'd0, 1'b1, 1'b0);
    dir   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    pinExpect("iv0_rev", 2'b01, 32'hFFFF_FFFF, 1'b1, 1'b0);
    stop = 1'b1;
    tick();
    stop = 1'b0;

    $display("[TB] position wrap through zero");
    doReset();
    applyStimulus(1'b0, 16'd3, 32'd2);
    repeat (6) tick();
    pinExpect("wrap_neg", 2'b11, 32'hFFFF_FFFE, 1'b0, 1'b1);
    applyStimulus(1'b1, 16'd3, 32'd3);
    repeat (9) tick();
    pinExpect("wrap_pos", 2'b10, 32'd1, 1'b0, 1'b1);

    $display("[TB] reset during a run");
    doReset();
    applyStimulus(1'b1, 16'd2, 32'd0);
    repeat (4) tick();
    pinExpect("pre_reset", 2'b11, 32'd2, 1'b1, 1'b0);
    RESET_IN = 1'b1;
    tick();
    pinExpect("mid_reset", 2'b00, 32'd0, 1'b0, 1'b0);
    RESET_IN = 1'b0;
    tick();

    $display("[TB] random stimulus");
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 15) == 0) dir = ~dir;
      if ($urandom_range(0, 9) == 0) interval = 16'($urandom_range(0, 5));
      if (start && !busy) step_target = 32'($urandom_range(0, 6));
      RESET_IN = ($urandom_range(0, 499) == 0);
      tick();
    end
    start    = 1'b0;
    stop     = 1'b0;
    RESET_IN = 1'b0;
    repeat (3) tick();
    @(negedge clk_sys);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
